// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter slice.
// Only the default counter width lives here; each module still takes WIDTH as a parameter.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 3;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-reflected-Gray conversion, parameterised by width.
// Adjacent binary values map to Gray values that differ in exactly one bit.
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray.sv
// Enabled Gray-code counter with a sticky wrap flag. Both outputs come straight from
// flip-flops; the Gray value is converted ahead of the register, so the outputs cannot glitch.
module gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [WIDTH-1:0] Output,
    output logic             Overflow
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap;

    assign w_bin_next = r_bin + WIDTH'(1);
    assign w_wrap     = &r_bin;

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_bin_next),
        .o_gray (w_gray_next)
    );

    // The Gray register is loaded on the same edge as the binary count, so Output has no extra latency.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
        end else if (En) begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign Output   = r_gray;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_gray.sv
// Randomised self-checking bench for the Gray counter: an integer reference model, a per-cycle
// compare process, a single-bit-change check on every step, and literal checks of the sequence and reset behaviour.
module tb_gray;

    localparam int W = 3;

    logic         Clk   = 1'b0;
    logic         Reset = 1'b0;
    logic         En    = 1'b0;
    logic [W-1:0] Output;
    logic         Overflow;

    gray #(
        .WIDTH (W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Output   (Output),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcount(input int v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    // Reference model: a plain integer count that wraps at 2^W, and a sticky flag.
    int m_bin     = 0;
    bit m_ovf     = 1'b0;
    int m_steps   = 0;
    int m_rst_cnt = 0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_bin = 0;
            m_ovf = 1'b0;
            m_rst_cnt++;
        end else if (En === 1'b1) begin
            if (m_bin == (1 << W) - 1) begin
                m_bin = 0;
                m_ovf = 1'b1;
            end else begin
                m_bin++;
            end
            m_steps++;
        end
    end

    int   last_steps = 0;
    int   last_rst   = 0;
    logic [W-1:0] prev_out = '0;

    always @(negedge Clk) begin
        check("cyc_output", 32'(Output), 32'(gray_of(m_bin)));
        check("cyc_overflow", 32'(Overflow), 32'(m_ovf));
        if (m_steps == last_steps + 1 && m_rst_cnt == last_rst) begin
            check("hamming1", 32'(popcount(int'(Output ^ prev_out))), 32'd1);
        end
        prev_out   = Output;
        last_steps = m_steps;
        last_rst   = m_rst_cnt;
    end

    // Reset must clear the outputs without waiting for a clock edge.
    always @(negedge Reset) begin
        #1;
        check("async_clr_out", 32'(Output), 32'd0);
        check("async_clr_ovf", 32'(Overflow), 32'd0);
    end

    task automatic tick(input logic e, input int exp_o, input logic exp_v, input string name);
        En = e;
        @(posedge Clk);
        #1;
        check({name, "_out"}, 32'(Output), 32'(exp_o));
        check({name, "_ovf"}, 32'(Overflow), 32'(exp_v));
    endtask

    int seq7 [7] = '{1, 3, 2, 6, 7, 5, 4};

    initial begin
        Reset = 1'b0;
        En    = 1'bx;
        repeat (3) @(posedge Clk);
        #1;
        check("in_reset_out", 32'(Output), 32'd0);
        check("in_reset_ovf", 32'(Overflow), 32'd0);
        #1 Reset = 1'b1;

        for (int i = 0; i < 7; i++) tick(1'b1, seq7[i], 1'b0, "seq");
        tick(1'b1, 0, 1'b1, "wrap");
        tick(1'b1, 1, 1'b1, "post_wrap1");
        tick(1'b1, 3, 1'b1, "post_wrap2");
        repeat (5) tick(1'b0, 3, 1'b1, "hold");
        tick(1'b1, 2, 1'b1, "post_wrap3");
        tick(1'b1, 6, 1'b1, "adv");
        tick(1'b1, 7, 1'b1, "adv");
        tick(1'b1, 5, 1'b1, "at101");

        #2 Reset = 1'b0;
        #1;
        check("rst_mid_out", 32'(Output), 32'd0);
        check("rst_mid_ovf", 32'(Overflow), 32'd0);
        @(posedge Clk);
        #1;
        check("rst_held_out", 32'(Output), 32'd0);
        #2 Reset = 1'b1;
        tick(1'b1, 1, 1'b0, "after_rel");

        #3 Reset = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("pulse_out", 32'(Output), 32'd0);
        check("pulse_ovf", 32'(Overflow), 32'd0);
        tick(1'b1, 1, 1'b0, "after_pulse");

        for (int c = 0; c < 400; c++) begin
            @(posedge Clk);
            #2;
            En = ($urandom % 4) != 0;
            if ($urandom % 40 == 0) begin
                #2 Reset = 1'b0;
                #($urandom_range(1, 3)) Reset = 1'b1;
            end
        end
        @(negedge Clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
